// File: rtl/cprv_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory port: one transaction
// in flight, in-order response routing, and an optional response timeout.
module cprv_mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int TIMEOUT    = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 valid_req_i,
  output logic [1:0]                 ready_req_o,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_req_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_req_i,
  input  logic [1:0]                 w_en_req_i,
  output logic [1:0]                 rvalid_req_o,
  input  logic [1:0]                 rready_req_i,
  output logic [DATA_WIDTH-1:0]      rdata_req_o,
  output logic                       rerr_req_o,
  output logic                       valid_mem_o,
  input  logic                       ready_mem_i,
  output logic [ADDR_WIDTH-1:0]      addr_mem_o,
  output logic [DATA_WIDTH-1:0]      wdata_mem_o,
  output logic                       w_en_mem_o,
  input  logic                       rvalid_mem_i,
  output logic                       rready_mem_o,
  input  logic [DATA_WIDTH-1:0]      rdata_mem_i
);

  // With the timeout disabled the counter is kept one bit wide and simply saturates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_SAT - CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t           state_reg;
  logic             owner_reg;
  logic             last_grant_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic grant_any;
  logic grant_idx;

  assign grant_any = (state_reg == IDLE) && (valid_req_i != 2'b00);
  assign grant_idx = (valid_req_i == 2'b11) ? ~last_grant_reg : valid_req_i[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign ready_req_o[gi]  = grant_any && (grant_idx == 1'(gi));
    assign rvalid_req_o[gi] = (owner_reg == 1'(gi)) &&
                              (((state_reg == RESP) && rvalid_mem_i) || (state_reg == ERR));
  end

  assign rdata_req_o  = (state_reg == RESP) ? rdata_mem_i : '0;
  assign rerr_req_o   = (state_reg == ERR);
  assign rready_mem_o = (state_reg == RESP) && rready_req_i[owner_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      valid_mem_o    <= 1'b0;
      addr_mem_o     <= '0;
      wdata_mem_o    <= '0;
      w_en_mem_o     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            addr_mem_o     <= addr_req_i[grant_idx];
            wdata_mem_o    <= wdata_req_i[grant_idx];
            w_en_mem_o     <= w_en_req_i[grant_idx];
            owner_reg      <= grant_idx;
            last_grant_reg <= grant_idx;
            valid_mem_o    <= 1'b1;
            state_reg      <= REQ;
          end
        end
        REQ: begin
          if (ready_mem_i) begin
            valid_mem_o <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (rvalid_mem_i) begin
            if (rready_req_i[owner_reg]) begin
              state_reg <= IDLE;
            end
          end else begin
            if (cnt_reg != CNT_SAT) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
            // The cycle that brings the count up to TIMEOUT is the last one spent waiting.
            if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
              state_reg <= ERR;
            end
          end
        end
        ERR: begin
          if (rready_req_i[owner_reg]) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Bench for cprv_mem_arbiter: two requester models and a memory model, with
// request/response scoreboards and per-cycle protocol checks.
`timescale 1ns/1ps
module tb_cprv_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int TO = 8;
  localparam logic [63:0] MEM_KEY = 64'h0000_0000_0000_DFAD;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        wen;
  } req_t;

  typedef struct {
    logic        port;
    logic [63:0] data;
    logic        err;
  } rsp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          valid_req_i;
  logic [1:0]          ready_req_o;
  logic [1:0][AW-1:0]  addr_req_i;
  logic [1:0][DW-1:0]  wdata_req_i;
  logic [1:0]          w_en_req_i;
  logic [1:0]          rvalid_req_o;
  logic [1:0]          rready_req_i;
  logic [DW-1:0]       rdata_req_o;
  logic                rerr_req_o;
  logic                valid_mem_o;
  logic                ready_mem_i;
  logic [AW-1:0]       addr_mem_o;
  logic [DW-1:0]       wdata_mem_o;
  logic                w_en_mem_o;
  logic                rvalid_mem_i;
  logic                rready_mem_o;
  logic [DW-1:0]       rdata_mem_i;

  always #5 clk = ~clk;

  cprv_mem_arbiter #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_req_i  (valid_req_i),
    .ready_req_o  (ready_req_o),
    .addr_req_i   (addr_req_i),
    .wdata_req_i  (wdata_req_i),
    .w_en_req_i   (w_en_req_i),
    .rvalid_req_o (rvalid_req_o),
    .rready_req_i (rready_req_i),
    .rdata_req_o  (rdata_req_o),
    .rerr_req_o   (rerr_req_o),
    .valid_mem_o  (valid_mem_o),
    .ready_mem_i  (ready_mem_i),
    .addr_mem_o   (addr_mem_o),
    .wdata_mem_o  (wdata_mem_o),
    .w_en_mem_o   (w_en_mem_o),
    .rvalid_mem_i (rvalid_mem_i),
    .rready_mem_o (rready_mem_o),
    .rdata_mem_i  (rdata_mem_i)
  );

  req_t pend0_q[$];
  req_t pend1_q[$];
  req_t exp_mem_q[$];
  rsp_t exp_rsp_q[$];
  logic exp_grant_q[$];

  int checks = 0;
  int failures = 0;

  // Test knobs
  int   stall_cycles = 0;
  int   resp_delay = 0;
  int   rready_hold = 0;
  int   exp_rready_lo = 0;
  logic resp_en = 1'b1;

  // Model state
  int          m_st = 0;
  int          m_stall = 0;
  int          m_wait = 0;
  int          valid_hi_cnt = 0;
  int          rready_lo_cnt = 0;
  int          resp_wait_cnt = 0;
  logic        resp_phase = 1'b0;
  logic        grant_prev = 1'b0;
  logic        m_owner = 1'b0;
  logic [63:0] m_addr = '0;
  req_t        m_first;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic port, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic wen, input logic [63:0] exp_data, input logic exp_err);
    req_t r;
    rsp_t e;
    r.addr = addr;
    r.wdata = wdata;
    r.wen = wen;
    e.port = port;
    e.data = exp_data;
    e.err = exp_err;
    if (port) pend1_q.push_back(r);
    else pend0_q.push_back(r);
    exp_grant_q.push_back(port);
    exp_mem_q.push_back(r);
    exp_rsp_q.push_back(e);
    $display("issue port=%0d addr=0x%0h wen=%0d exp_data=0x%0h exp_err=%0d",
             port, addr, wen, exp_data, exp_err);
  endtask

  task automatic drive_inputs();
    valid_req_i[0] = (pend0_q.size() != 0);
    if (pend0_q.size() != 0) begin
      addr_req_i[0]  = pend0_q[0].addr;
      wdata_req_i[0] = pend0_q[0].wdata;
      w_en_req_i[0]  = pend0_q[0].wen;
    end else begin
      addr_req_i[0]  = {$urandom, $urandom};
      wdata_req_i[0] = {$urandom, $urandom};
      w_en_req_i[0]  = 1'($urandom);
    end
    valid_req_i[1] = (pend1_q.size() != 0);
    if (pend1_q.size() != 0) begin
      addr_req_i[1]  = pend1_q[0].addr;
      wdata_req_i[1] = pend1_q[0].wdata;
      w_en_req_i[1]  = pend1_q[0].wen;
    end else begin
      addr_req_i[1]  = {$urandom, $urandom};
      wdata_req_i[1] = {$urandom, $urandom};
      w_en_req_i[1]  = 1'($urandom);
    end
    ready_mem_i  = valid_mem_o && (m_stall >= stall_cycles);
    rvalid_mem_i = (m_st == 2);
    rdata_mem_i  = (m_st == 2) ? (m_addr ^ MEM_KEY) : {$urandom, $urandom};
    // While holding off, only the owner's rready drops; the other bit stays high.
    if (m_st == 2 && rready_hold > 0) rready_req_i = m_owner ? 2'b01 : 2'b10;
    else rready_req_i = 2'b11;
  endtask

  task automatic sample_outputs();
    req_t r;
    rsp_t e;
    logic g;
    logic p;
    if (grant_prev) check("grant_to_valid_mem", 64'(valid_mem_o), 64'd1);
    grant_prev = 1'b0;

    if (ready_req_o != 2'b00) begin
      check("ready_not_both", 64'(ready_req_o == 2'b11), 64'd0);
      check("ready_without_valid", 64'(ready_req_o & ~valid_req_i), 64'd0);
      g = ready_req_o[1];
      if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(ready_req_o), 64'd0);
      else check("grant_port", 64'(g), 64'(exp_grant_q.pop_front()));
      if (g && pend1_q.size() != 0) r = pend1_q.pop_front();
      if (!g && pend0_q.size() != 0) r = pend0_q.pop_front();
      m_owner = g;
      grant_prev = 1'b1;
    end

    if (rvalid_req_o != 2'b00) begin
      p = rvalid_req_o[1];
      check("rvalid_onehot", 64'($countones(rvalid_req_o)), 64'd1);
      if (rerr_req_o) begin
        check("timeout_wait", 64'(resp_wait_cnt), 64'(TO));
        check("err_rdata_zero", rdata_req_o, 64'd0);
        check("err_rready_mem", 64'(rready_mem_o), 64'd0);
      end else begin
        check("rready_pass", 64'(rready_mem_o), 64'(rready_req_i[p]));
        if (!rready_mem_o) rready_lo_cnt++;
      end
      if (rready_req_i[p]) begin
        if (exp_rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rvalid_req_o), 64'd0);
        end else begin
          e = exp_rsp_q.pop_front();
          check("rsp_port", 64'(p), 64'(e.port));
          check("rsp_data", rdata_req_o, e.data);
          check("rsp_err", 64'(rerr_req_o), 64'(e.err));
          check("rready_low_cycles", 64'(rready_lo_cnt), 64'(exp_rready_lo));
          $display("response port=%0d data=0x%0h err=%0d", p, rdata_req_o, rerr_req_o);
        end
        rready_lo_cnt = 0;
        resp_phase = 1'b0;
        if (m_st == 2) m_st = 0;
      end else if (rready_hold > 0) begin
        rready_hold--;
      end
    end else if (resp_phase) begin
      resp_wait_cnt++;
    end

    if (valid_mem_o) begin
      valid_hi_cnt++;
      if (valid_hi_cnt == 1) begin
        m_first.addr = addr_mem_o;
        m_first.wdata = wdata_mem_o;
        m_first.wen = w_en_mem_o;
      end else begin
        check("req_addr_stable", addr_mem_o, m_first.addr);
        check("req_wdata_stable", wdata_mem_o, m_first.wdata);
        check("req_wen_stable", 64'(w_en_mem_o), 64'(m_first.wen));
      end
      if (ready_mem_i) begin
        check("valid_mem_cycles", 64'(valid_hi_cnt), 64'(stall_cycles + 1));
        if (exp_mem_q.size() == 0) begin
          check("mem_req_unexpected", 64'(valid_mem_o), 64'd0);
        end else begin
          r = exp_mem_q.pop_front();
          check("mem_addr", addr_mem_o, r.addr);
          check("mem_wdata", wdata_mem_o, r.wdata);
          check("mem_wen", 64'(w_en_mem_o), 64'(r.wen));
        end
        valid_hi_cnt = 0;
        m_stall = 0;
        m_addr = addr_mem_o;
        m_wait = 0;
        m_st = resp_en ? 1 : 0;
        resp_wait_cnt = 0;
        resp_phase = 1'b1;
      end else begin
        m_stall++;
      end
    end

    if (m_st == 1) begin
      if (m_wait >= resp_delay) m_st = 2;
      else m_wait++;
    end
  endtask

  initial begin : bench_cycle
    valid_req_i = '0;
    addr_req_i = '0;
    wdata_req_i = '0;
    w_en_req_i = '0;
    rready_req_i = '0;
    ready_mem_i = 1'b0;
    rvalid_mem_i = 1'b0;
    rdata_mem_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_st = 0;
        m_stall = 0;
        m_wait = 0;
        valid_hi_cnt = 0;
        rready_lo_cnt = 0;
        resp_wait_cnt = 0;
        resp_phase = 1'b0;
        grant_prev = 1'b0;
        rready_hold = 0;
        valid_req_i = '0;
        ready_mem_i = 1'b0;
        rvalid_mem_i = 1'b0;
        rdata_mem_i = '0;
        rready_req_i = '0;
      end else begin
        drive_inputs();
        #4;
        if (rst_n) sample_outputs();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((pend0_q.size() + pend1_q.size() + exp_rsp_q.size()) != 0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(pend0_q.size() + pend1_q.size() + exp_rsp_q.size()), 64'd0);
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_valid_mem", 64'(valid_mem_o), 64'd0);
    check("rst_addr_mem", addr_mem_o, 64'd0);
    check("rst_wdata_mem", wdata_mem_o, 64'd0);
    check("rst_wen_mem", 64'(w_en_mem_o), 64'd0);
    check("rst_ready_req", 64'(ready_req_o), 64'd0);
    check("rst_rvalid_req", 64'(rvalid_req_o), 64'd0);
    check("rst_rready_mem", 64'(rready_mem_o), 64'd0);
    check("rst_rerr", 64'(rerr_req_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Port 1 load, memory answers after 2 cycles
    resp_delay = 2;
    issue(1'b1, 64'h100, 64'h0, 1'b0, 64'hDEAD, 1'b0);
    wait_idle("port1_load");

    // Both ports contend for 4 transactions; last grant was port 1
    resp_delay = 0;
    issue(1'b0, 64'h200, 64'h1111, 1'b1, 64'h200 ^ MEM_KEY, 1'b0);
    issue(1'b1, 64'h300, 64'h0, 1'b0, 64'h300 ^ MEM_KEY, 1'b0);
    issue(1'b0, 64'h208, 64'h2222, 1'b1, 64'h208 ^ MEM_KEY, 1'b0);
    issue(1'b1, 64'h308, 64'h0, 1'b0, 64'h308 ^ MEM_KEY, 1'b0);
    wait_idle("round_robin");

    // Port 0 store with memory stalling 5 cycles
    stall_cycles = 5;
    issue(1'b0, 64'h400, 64'hCAFE_F00D_1234_5678, 1'b1, 64'h400 ^ MEM_KEY, 1'b0);
    wait_idle("stall_store");
    stall_cycles = 0;

    // Response backpressure for 3 cycles
    rready_hold = 3;
    exp_rready_lo = 3;
    issue(1'b1, 64'h500, 64'h0, 1'b0, 64'h500 ^ MEM_KEY, 1'b0);
    wait_idle("backpressure");
    exp_rready_lo = 0;

    // Memory never answers: timeout error beat
    resp_en = 1'b0;
    issue(1'b0, 64'h600, 64'h0, 1'b0, 64'h0, 1'b1);
    wait_idle("timeout");
    resp_en = 1'b1;

    // Reset while waiting in REQ
    stall_cycles = 20;
    issue(1'b0, 64'h700, 64'h77, 1'b1, 64'h700 ^ MEM_KEY, 1'b0);
    begin
      int n;
      n = 0;
      while (!valid_mem_o && n < 50) begin
        tick();
        n++;
      end
      check("reset_test_req_seen", 64'(valid_mem_o), 64'd1);
    end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_mem", 64'(valid_mem_o), 64'd0);
    check("async_rst_rvalid", 64'(rvalid_req_o), 64'd0);
    check("async_rst_addr_mem", addr_mem_o, 64'd0);
    pend0_q.delete();
    pend1_q.delete();
    exp_mem_q.delete();
    exp_rsp_q.delete();
    exp_grant_q.delete();
    stall_cycles = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_rvalid", 64'(rvalid_req_o), 64'd0);
    end
    issue(1'b0, 64'h800, 64'h0, 1'b0, 64'h800 ^ MEM_KEY, 1'b0);
    issue(1'b1, 64'h900, 64'h0, 1'b0, 64'h900 ^ MEM_KEY, 1'b0);
    wait_idle("post_reset_grant");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
